// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared constants and state encoding for the IM loader
// Contents:
//   BASE_ADDR  byte address of the first written word (boot PC)
//   IM_DEPTH   IM capacity in words, also the largest legal word_count
//   CNT_W      width of word_count / words_done
//   state_t    loader FSM state encoding
package im_loader_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h0000_3000;
  localparam int          IM_DEPTH  = 8192;
  localparam int          CNT_W     = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/im_loader_byte_packer.sv
// rtl/im_loader_byte_packer.sv - 8->32 big-endian byte packer for the IM loader
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clear        restart packing at byte 0 (accepted load start)
//   accept       a byte is consumed this cycle
//   in_data      byte being consumed
//   word         packed word including the byte consumed this cycle
//   word_valid   this cycle's accepted byte completes a word
module im_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] word_q;
  logic [1:0]  idx;

  // Look-ahead view so the top can capture the complete word on the same
  // edge that consumes the fourth byte.
  assign word       = {word_q[23:0], in_data};
  assign word_valid = accept && (idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      idx    <= '0;
    end else if (clear) begin
      word_q <= '0;
      idx    <= '0;
    end else if (accept) begin
      word_q <= word;
      idx    <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-stream loader writing packed words into instruction memory
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   start, word_count       load request and number of words to load
//   in_valid, in_data       byte stream in (MSB of each word first)
//   in_ready                loader accepts a byte this cycle
//   im_we, im_addr, im_wdata IM write port
//   cpu_hold, busy          fetch-stage hold / load in progress
//   done, err               last load completed / last start rejected
//   words_done, checksum    progress and mod-2^32 sum of written words
module im_loader
  import im_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_done,
  output logic [31:0]      checksum
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] words_inc;
  logic             start_ok;
  logic             count_zero;
  logic             count_bad;
  logic             accept;
  logic             last_word;
  logic [31:0]      packed_word;
  logic             word_valid;

  // start is only honoured while no load is running
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign count_zero = (word_count == '0);
  assign count_bad  = (word_count > CNT_W'(IM_DEPTH));
  assign accept     = in_valid && in_ready;
  assign words_inc  = words_done + 1'b1;
  assign last_word  = (words_inc == count_q);

  assign in_ready = (state == ST_RECV);
  assign im_we    = (state == ST_WRITE);
  assign busy     = (state == ST_RECV) || (state == ST_WRITE);
  assign cpu_hold = busy;

  im_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .accept     (accept),
    .in_data    (in_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (count_zero)     state_nxt = ST_DONE;
          else if (count_bad) state_nxt = ST_IDLE;
          else                state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (word_valid) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        state_nxt = last_word ? ST_DONE : ST_RECV;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      im_addr    <= BASE_ADDR;
      im_wdata   <= '0;
      words_done <= '0;
      checksum   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (start_ok) begin
        if (count_zero) begin
          done       <= 1'b1;
          err        <= 1'b0;
          words_done <= '0;
          checksum   <= '0;
        end else if (count_bad) begin
          err  <= 1'b1;
          done <= 1'b0;
        end else begin
          count_q    <= word_count;
          words_done <= '0;
          checksum   <= '0;
          err        <= 1'b0;
          done       <= 1'b0;
          im_addr    <= BASE_ADDR;
        end
      end

      // Capture the word as its last byte arrives; it then stays on
      // im_wdata through the WRITE cycle and afterwards.
      if ((state == ST_RECV) && word_valid) begin
        im_wdata <= packed_word;
      end

      if (state == ST_WRITE) begin
        words_done <= words_inc;
        checksum   <= checksum + im_wdata;
        im_addr    <= im_addr + 32'd4;
        if (last_word) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed self-checking bench for im_loader
module tb_im_loader;
  import im_loader_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] word_count = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready, im_we, cpu_hold, busy, done, err;
  logic [31:0]      im_addr, im_wdata, checksum;
  logic [CNT_W-1:0] words_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  tx[$];
  int          viol = 0;
  bit          busy_seen = 0;
  bit          prev_we = 0;
  int          base;

  always #5 clk = ~clk;

  im_loader dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .checksum   (checksum)
  );

  // write monitor: logs IM writes, flags multi-cycle strobes and in_ready during WRITE
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_we) begin
        log_addr.push_back(im_addr);
        log_data.push_back(im_wdata);
        if (in_ready) viol++;
        if (prev_we) viol++;
      end
      if (busy) busy_seen = 1;
      prev_we = im_we;
    end else begin
      prev_we = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic do_start(input int cnt);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = CNT_W'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // returns at posedge+1 just after the last queued byte was consumed
  task automatic send(input bit rnd);
    int  i = 0;
    int  cyc = 0;
    bit  fire;
    while (i < tx.size() && cyc < 2000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = tx[i];
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (i < tx.size()) check("send_timeout", 32'(i), 32'(tx.size()));
    tx.delete();
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < log_addr.size()) begin
      check({tag, "_addr"}, log_addr[idx], a);
      check({tag, "_data"}, log_data[idx], d);
    end else begin
      check({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #12;
    // reset state
    check("rst_addr", im_addr, 32'h0000_3000);
    check("rst_flags", {26'd0, in_ready, im_we, busy, done, err, cpu_hold}, 32'd0);
    check("rst_wdone", 32'(words_done), 32'd0);
    check("rst_csum", checksum, 32'd0);
    rst_n = 1'b1;

    // 1: two-word load, fixed bytes
    base = log_addr.size();
    do_start(2);
    check("t1_hold", {30'd0, cpu_hold, busy}, 32'd3);
    tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send(0);
    check("t1_latency_we", 32'(im_we), 32'd1);
    check("t1_latency_addr", im_addr, 32'h0000_3004);
    wait_done("t1_done");
    check_write("t1_w0", base, 32'h0000_3000, 32'h1234_5678);
    check_write("t1_w1", base + 1, 32'h0000_3004, 32'h9ABC_DEF0);
    check("t1_wdone", 32'(words_done), 32'd2);
    check("t1_csum", checksum, 32'hACF1_3568);
    check("t1_hold_after", {30'd0, cpu_hold, busy}, 32'd0);

    // 2: zero-word load
    base = log_addr.size();
    busy_seen = 0;
    do_start(0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_wdone", 32'(words_done), 32'd0);
    check("t2_csum", checksum, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_nowrite", 32'(log_addr.size()), 32'(base));
    check("t2_busy_seen", 32'(busy_seen), 32'd0);

    // 3: oversize count rejected, then a good load
    do_start(8193);
    check("t3_err", 32'(err), 32'd1);
    check("t3_idle", {28'd0, done, busy, in_ready, cpu_hold}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t3_nowrite", 32'(log_addr.size()), 32'(base));
    do_start(1);
    check("t3_err_clr", 32'(err), 32'd0);
    tx = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send(0);
    wait_done("t3_done");
    check_write("t3_w0", base, 32'h0000_3000, 32'hA1B2_C3D4);

    // 4: random in_valid gaps, three words
    base = log_addr.size();
    viol = 0;
    do_start(3);
    for (int b = 1; b <= 12; b++) tx.push_back(8'(b));
    send(1);
    wait_done("t4_done");
    check("t4_nwrites", 32'(log_addr.size() - base), 32'd3);
    check_write("t4_w0", base, 32'h0000_3000, 32'h0102_0304);
    check_write("t4_w1", base + 1, 32'h0000_3004, 32'h0506_0708);
    check_write("t4_w2", base + 2, 32'h0000_3008, 32'h090A_0B0C);
    check("t4_csum", checksum, 32'h0F12_1518);
    check("t4_viol", 32'(viol), 32'd0);

    // 5: asynchronous reset mid-load, then restart
    do_start(4);
    tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    send(0);
    @(posedge clk); #1;
    check("t5_wdone_mid", 32'(words_done), 32'd2);
    check("t5_csum_mid", checksum, 32'h6688_AACC);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_addr", im_addr, 32'h0000_3000);
    check("t5_rst_flags", {26'd0, in_ready, im_we, busy, done, err, cpu_hold}, 32'd0);
    check("t5_rst_wdone", 32'(words_done), 32'd0);
    check("t5_rst_csum", checksum, 32'd0);
    check("t5_rst_wdata", im_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = log_addr.size();
    do_start(1);
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(0);
    wait_done("t5_done");
    check_write("t5_w0", base, 32'h0000_3000, 32'hDEAD_BEEF);
    check("t5_csum", checksum, 32'hDEAD_BEEF);

    // 6: start while busy ignored, checksum wrap
    base = log_addr.size();
    do_start(2);
    tx = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send(0);
    start = 1'b1;
    word_count = CNT_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    tx = '{8'h00, 8'h00, 8'h00, 8'h02};
    send(0);
    wait_done("t6_done");
    check("t6_nwrites", 32'(log_addr.size() - base), 32'd2);
    check("t6_wdone", 32'(words_done), 32'd2);
    check("t6_csum", checksum, 32'h0000_0001);
    check_write("t6_w1", base + 1, 32'h0000_3004, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
